// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit owning the HI/LO pair.
// Multiply is a radix-2 shift-add on a 2*WORD_LEN accumulator; divide is a
// radix-2 restoring divider that keeps the remainder in the upper half of the
// same accumulator and shifts quotient bits in at the bottom. Signed ops run on
// magnitudes and the signs are applied in the FIX state.
module hilo_muldiv_unit #(
    parameter int WORD_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [WORD_LEN-1:0] rs_val,
    input  logic [WORD_LEN-1:0] rt_val,
    input  logic                read_hilo,
    output logic [WORD_LEN-1:0] hi,
    output logic [WORD_LEN-1:0] lo,
    output logic                busy,
    output logic                done,
    output logic                stall
);

    localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic                    is_div;       // operation in flight is a divide
    logic                    neg_q;        // negate product / quotient at FIX
    logic                    neg_r;        // negate remainder at FIX
    logic                    div_zero;     // divisor was zero
    logic [WORD_LEN-1:0]     mag;          // multiplicand magnitude or divisor magnitude
    logic [WORD_LEN-1:0]     dividend_raw; // untouched rs, returned in HI on divide by zero
    logic [2*WORD_LEN-1:0]   acc;          // product, or {remainder, dividend/quotient}

    // Issue-side decode of the incoming operands
    logic                    signed_op;
    logic                    div_op;
    logic [WORD_LEN-1:0]     abs_rs;
    logic [WORD_LEN-1:0]     abs_rt;

    // One iteration of each datapath
    logic [WORD_LEN:0]       mul_sum;
    logic [2*WORD_LEN-1:0]   mul_next;
    logic [WORD_LEN:0]       div_shift;
    logic [WORD_LEN:0]       div_diff;
    logic                    div_ge;
    logic [2*WORD_LEN-1:0]   div_next;

    // Final sign correction
    logic [2*WORD_LEN-1:0]   prod_fix;
    logic [WORD_LEN-1:0]     quot_fix;
    logic [WORD_LEN-1:0]     rem_fix;

    assign busy  = (state != IDLE);
    assign stall = busy & (start | read_hilo);

    // Decode the operation and take magnitudes of signed operands
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        div_op    = (op == OP_DIV) || (op == OP_DIVU);
        abs_rs    = (signed_op && rs_val[WORD_LEN-1]) ? -rs_val : rs_val;
        abs_rt    = (signed_op && rt_val[WORD_LEN-1]) ? -rt_val : rt_val;
    end

    // Shift-add step: add multiplicand on LSB of multiplier, shift right with carry
    always_comb begin
        mul_sum  = {1'b0, acc[2*WORD_LEN-1:WORD_LEN]} + (acc[0] ? {1'b0, mag} : '0);
        mul_next = {mul_sum, acc[WORD_LEN-1:1]};
    end

    // Restoring divide step: shift in next dividend bit, subtract divisor if it fits
    always_comb begin
        div_shift = {acc[2*WORD_LEN-1:WORD_LEN], acc[WORD_LEN-1]};
        div_diff  = div_shift - {1'b0, mag};
        div_ge    = ~div_diff[WORD_LEN];
        div_next  = {(div_ge ? div_diff[WORD_LEN-1:0] : div_shift[WORD_LEN-1:0]),
                     acc[WORD_LEN-2:0], div_ge};
    end

    // Apply result signs; remainder follows the dividend's sign
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quot_fix = neg_q ? -acc[WORD_LEN-1:0] : acc[WORD_LEN-1:0];
        rem_fix  = neg_r ? -acc[2*WORD_LEN-1:WORD_LEN] : acc[2*WORD_LEN-1:WORD_LEN];
    end

    // Control FSM with HI/LO writes and the registered done pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            is_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
            mag          <= '0;
            dividend_raw <= '0;
            acc          <= '0;
            hi           <= '0;
            lo           <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MULT || op == OP_MULTU || div_op) begin
                            is_div       <= div_op;
                            neg_q        <= signed_op & (rs_val[WORD_LEN-1] ^ rt_val[WORD_LEN-1]);
                            neg_r        <= signed_op & rs_val[WORD_LEN-1];
                            div_zero     <= (rt_val == '0);
                            dividend_raw <= rs_val;
                            mag          <= div_op ? abs_rt : abs_rs;
                            acc          <= {{WORD_LEN{1'b0}}, (div_op ? abs_rs : abs_rt)};
                            count        <= CNT_W'(WORD_LEN - 1);
                            state        <= CALC;
                        end else if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WORD_LEN-1:WORD_LEN];
                        lo <= prod_fix[WORD_LEN-1:0];
                    end else if (div_zero) begin
                        hi <= dividend_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed vector table, hazard and reset
// sequences, then random operations checked against a plain-arithmetic model.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic          read_hilo;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic          stall;

    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   m_hi;
    logic [31:0]   m_lo;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl [13];

    hilo_muldiv_unit #(.WORD_LEN(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .read_hilo (read_hilo),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: architectural result of one HI/LO instruction, as {hi, lo}
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] ch,
                                          input logic [31:0] cl);
        longint      sa;
        longint      sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: r = 64'(sa * sb);
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                  else            r = {32'(sa % sb), 32'(sa / sb)};
            3'd3: if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                  else            r = {a % b, a / b};
            3'd4: r = {a, cl};
            3'd5: r = {ch, a};
            default: r = {ch, cl};
        endcase
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one instruction from IDLE and follow it to completion
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] xh, input logic [31:0] xl);
        int k;
        int busy_cyc;
        bit moved;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        #1;
        check1("stall_at_issue", stall, 1'b0);
        step();
        start = 1'b0;
        if (o < 3'd4) begin
            k = 0; busy_cyc = 0; moved = 0;
            while (!done && k < 100) begin
                if (busy) busy_cyc++;
                if (hi !== m_hi || lo !== m_lo) moved = 1;
                step();
                k++;
            end
            check32("latency", 32'(k), 32'd33);
            check32("busy_cycles", 32'(busy_cyc), 32'd33);
            check1("hilo_stable_in_calc", moved, 1'b0);
            check32("hi", hi, xh);
            check32("lo", lo, xl);
            check1("busy_in_done_cycle", busy, 1'b0);
            step();
            check1("done_one_cycle", done, 1'b0);
        end else begin
            check32("hi", hi, xh);
            check32("lo", lo, xl);
            check1("busy_after_move", busy, 1'b0);
            check1("done_after_move", done, 1'b0);
        end
        m_hi = xh;
        m_lo = xl;
        $display("op=%0d rs=%08h rt=%08h -> hi=%08h lo=%08h", o, a, b, hi, lo);
    endtask

    initial begin
        logic [63:0] e;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          k;
        bit          bad;

        tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[1]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003};
        tbl[4]  = '{3'd3, 32'h00000055, 32'd0,        32'h00000055, 32'hFFFFFFFF};
        tbl[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[6]  = '{3'd4, 32'hCAFEF00D, 32'd9,        32'hCAFEF00D, 32'h80000000};
        tbl[7]  = '{3'd5, 32'h12345678, 32'd9,        32'hCAFEF00D, 32'h12345678};
        tbl[8]  = '{3'd6, 32'h00000001, 32'd1,        32'hCAFEF00D, 32'h12345678};
        tbl[9]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[11] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[12] = '{3'd2, 32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 32'hFFFFFFFF};

        reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0; read_hilo = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clock);
        #1;
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check1("reset_stall", stall, 1'b0);
        reset = 1'b0;
        read_hilo = 1'b0;
        step();

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo);
        end

        // Hazards while a MULT is in flight
        op = 3'd0; rs_val = 32'h00001234; rt_val = 32'hFFFF0000; start = 1'b1;
        e = model(3'd0, 32'h00001234, 32'hFFFF0000, m_hi, m_lo);
        step();
        start = 1'b0;
        k = 0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            read_hilo = 1'b1;
            #1;
            if (stall !== 1'b1) bad = 1;
            step();
            k++;
        end
        check1("stall_on_read_hilo", bad, 1'b0);
        read_hilo = 1'b0;
        op = 3'd1; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
        #1;
        check1("stall_on_start_busy", stall, 1'b1);
        bad = 0;
        while (!done && k < 100) begin
            if (stall !== 1'b1) bad = 1;
            step();
            k++;
        end
        check1("stall_held_until_idle", bad, 1'b0);
        check32("hazard_latency", 32'(k), 32'd33);
        check32("hazard_first_hi", hi, e[63:32]);
        check32("hazard_first_lo", lo, e[31:0]);
        m_hi = e[63:32];
        m_lo = e[31:0];
        check1("stall_start_in_done_cycle", stall, 1'b0);
        read_hilo = 1'b1;
        #1;
        check1("stall_read_hilo_idle", stall, 1'b0);
        read_hilo = 1'b0;
        step();
        start = 1'b0;
        check1("represented_start_accepted", busy, 1'b1);
        k = 0;
        while (!done && k < 100) begin
            step();
            k++;
        end
        check32("second_latency", 32'(k), 32'd33);
        check32("second_hi", hi, 32'd0);
        check32("second_lo", lo, 32'd63);
        m_hi = 32'd0;
        m_lo = 32'd63;
        $display("hazard sequence: hi=%08h lo=%08h", hi, lo);
        step();

        // Reset in the middle of a DIV
        op = 3'd2; rs_val = 32'd1000; rt_val = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (21) step();
        check1("busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        #1;
        check32("midreset_hi", hi, 32'd0);
        check32("midreset_lo", lo, 32'd0);
        check1("midreset_busy", busy, 1'b0);
        check1("midreset_done", done, 1'b0);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        step();
        check1("idle_after_reset", busy, 1'b0);
        run_op(3'd5, 32'h00001234, 32'd0, 32'd0, 32'h00001234);
        $display("reset mid-DIV: hi=%08h lo=%08h", hi, lo);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            e = model(ro, ra, rb, m_hi, m_lo);
            run_op(ro, ra, rb, e[63:32], e[31:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
